// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stalls, branch flushes,
// memory-wait freeze with timeout halt, EX forwarding selects and saturating event counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    input  logic [4:0]       EX_Rs,
    input  logic             EX_BranchTaken,
    input  logic             MEM_RegWrite,
    input  logic [4:0]       MEM_WriteReg,
    input  logic             WB_RegWrite,
    input  logic [4:0]       WB_WriteReg,
    input  logic             MEM_Req,
    input  logic             MEM_Ready,
    output logic             StallIF,
    output logic             StallID,
    output logic             StallEXMEM,
    output logic             FlushIFID,
    output logic             FlushIDEX,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t           state_q;
    logic [WCW-1:0]   wait_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic hold, halted, load_use;

    assign hold     = MEM_Req & ~MEM_Ready;
    assign halted   = (state_q == HALT);
    assign load_use = EX_MemRead & (EX_Rt != 5'd0) &
                      ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt)));

    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
        if (MEM_RegWrite && MEM_WriteReg != 5'd0 && MEM_WriteReg == r)
            return 2'b10;
        else if (WB_RegWrite && WB_WriteReg != 5'd0 && WB_WriteReg == r)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Priority: halt > memory hold > taken branch > load-use.
    always_comb begin
        StallIF    = 1'b0;
        StallID    = 1'b0;
        StallEXMEM = 1'b0;
        FlushIFID  = 1'b0;
        FlushIDEX  = 1'b0;
        ForwardA   = 2'b00;
        ForwardB   = 2'b00;
        if (!RESET) begin
            ForwardA = fwd_sel(EX_Rs);
            ForwardB = fwd_sel(EX_Rt);
            if (halted || hold) begin
                StallIF    = 1'b1;
                StallID    = 1'b1;
                StallEXMEM = 1'b1;
            end else if (EX_BranchTaken) begin
                FlushIFID = 1'b1;
                FlushIDEX = 1'b1;
            end else if (load_use) begin
                StallIF   = 1'b1;
                StallID   = 1'b1;
                FlushIDEX = 1'b1;
            end
        end
    end

    assign MemTimeout = halted & ~RESET;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: if (hold) begin
                    state_q    <= MEM_WAIT;
                    wait_cnt_q <= WCW'(1);
                end
                MEM_WAIT: if (hold) begin
                    // wait_cnt_q counts hold cycles already seen; this one is the next.
                    if (wait_cnt_q == WCW'(MEM_TIMEOUT - 1))
                        state_q <= HALT;
                    wait_cnt_q <= wait_cnt_q + WCW'(1);
                end else begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
                HALT: ;
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
            endcase
            if (StallIF && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((FlushIFID || FlushIDEX) && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=8, CNT_W=4).
module tb_pipe_hazard_ctrl;
    localparam int MT = 8;
    localparam int CW = 4;

    logic CLK = 1'b0, RESET = 1'b1;
    logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_Rt = '0, EX_Rs = '0, MEM_WriteReg = '0, WB_WriteReg = '0;
    logic ID_UsesRt = 0, EX_MemRead = 0, EX_BranchTaken = 0, MEM_RegWrite = 0, WB_RegWrite = 0;
    logic MEM_Req = 0, MEM_Ready = 0;
    logic StallIF, StallID, StallEXMEM, FlushIFID, FlushIDEX, MemTimeout;
    logic [1:0] ForwardA, ForwardB;
    logic [CW-1:0] StallCount, FlushCount;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_Rs(EX_Rs), .EX_BranchTaken(EX_BranchTaken),
        .MEM_RegWrite(MEM_RegWrite), .MEM_WriteReg(MEM_WriteReg), .WB_RegWrite(WB_RegWrite),
        .WB_WriteReg(WB_WriteReg), .MEM_Req(MEM_Req), .MEM_Ready(MEM_Ready),
        .StallIF(StallIF), .StallID(StallID), .StallEXMEM(StallEXMEM), .FlushIFID(FlushIFID),
        .FlushIDEX(FlushIDEX), .ForwardA(ForwardA), .ForwardB(ForwardB), .MemTimeout(MemTimeout),
        .StallCount(StallCount), .FlushCount(FlushCount));

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic sif, sid, sem, fif, fid;
        logic [1:0] fa, fb;
        logic mt;
    } vec_t;

    typedef struct {
        string tag;
        vec_t v;
        logic [CW-1:0] sc, fc;
    } item_t;

    item_t sb[$];
    int n_cmp = 0, n_err = 0;
    int m_sc = 0, m_fc = 0;

    function automatic vec_t V(logic sif, sid, sem, fif, fid, logic [1:0] fa, fb, logic mt);
        vec_t r;
        r = {sif, sid, sem, fif, fid, fa, fb, mt};
        return r;
    endfunction

    vec_t IDLE, LU, BR, HOLD, HLT;

    // Push expectation for the current input set, check it mid-cycle, then advance a clock.
    task automatic cyc(input string tag, input vec_t e);
        item_t it;
        vec_t obs;
        it.tag = tag; it.v = e; it.sc = CW'(m_sc); it.fc = CW'(m_fc);
        sb.push_back(it);
        if (RESET) begin
            m_sc = 0; m_fc = 0;
        end else begin
            if (e.sif && m_sc < 15) m_sc++;
            if ((e.fif || e.fid) && m_fc < 15) m_fc++;
        end
        @(negedge CLK);
        it = sb.pop_front();
        obs = {StallIF, StallID, StallEXMEM, FlushIFID, FlushIDEX, ForwardA, ForwardB, MemTimeout};
        n_cmp++;
        assert (obs === it.v) else begin
            n_err++;
            $error("FAIL %s outs(sif sid sem fif fid fa fb mt): got %b want %b", it.tag, obs, it.v);
        end
        n_cmp++;
        assert (StallCount === it.sc) else begin
            n_err++;
            $error("FAIL %s StallCount: got %0d want %0d", it.tag, StallCount, it.sc);
        end
        n_cmp++;
        assert (FlushCount === it.fc) else begin
            n_err++;
            $error("FAIL %s FlushCount: got %0d want %0d", it.tag, FlushCount, it.fc);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        IDLE = V(0,0,0,0,0,2'b00,2'b00,0);
        LU   = V(1,1,0,0,1,2'b00,2'b00,0);
        BR   = V(0,0,0,1,1,2'b00,2'b00,0);
        HOLD = V(1,1,1,0,0,2'b00,2'b00,0);
        HLT  = V(1,1,1,0,0,2'b00,2'b00,1);

        @(posedge CLK); #1;
        cyc("reset", IDLE);
        RESET = 0;
        cyc("idle", IDLE);

        // load-use on Rs, then released
        EX_MemRead = 1; EX_Rt = 5'd2; ID_Rs = 5'd2;
        cyc("lu_rs", LU);
        EX_MemRead = 0;
        cyc("lu_after", IDLE);
        // load-use on Rt only when ID reads Rt
        EX_MemRead = 1; ID_Rs = 5'd3; ID_Rt = 5'd2; ID_UsesRt = 1;
        cyc("lu_rt", LU);
        ID_UsesRt = 0;
        cyc("lu_rt_unused", IDLE);
        EX_Rt = 5'd0; ID_Rs = 5'd0;
        cyc("lu_r0", IDLE);
        // branch beats load-use
        EX_Rt = 5'd2; ID_Rs = 5'd2; EX_BranchTaken = 1;
        cyc("branch_lu", BR);
        EX_BranchTaken = 0;

        // memory hold overrides the pending load-use, which re-appears on release
        MEM_Req = 1; MEM_Ready = 0;
        for (int i = 1; i <= 3; i++) cyc($sformatf("hold%0d", i), HOLD);
        MEM_Ready = 1;
        cyc("release_lu", LU);
        MEM_Req = 0; MEM_Ready = 0; EX_MemRead = 0; EX_Rt = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0;
        cyc("release_idle", IDLE);

        // forwarding
        MEM_RegWrite = 1; MEM_WriteReg = 5'd5; WB_RegWrite = 1; WB_WriteReg = 5'd5; EX_Rs = 5'd5;
        cyc("fwd_mem_wins", V(0,0,0,0,0,2'b10,2'b00,0));
        EX_Rt = 5'd5; MEM_RegWrite = 0;
        cyc("fwd_wb", V(0,0,0,0,0,2'b01,2'b01,0));
        MEM_RegWrite = 1; MEM_WriteReg = 5'd0; WB_WriteReg = 5'd0; EX_Rs = 5'd0; EX_Rt = 5'd0;
        cyc("fwd_r0", IDLE);
        MEM_RegWrite = 0; WB_RegWrite = 0;

        // timeout: 8 hold cycles, halt from the 9th
        MEM_Req = 1; MEM_Ready = 0;
        for (int i = 1; i <= MT; i++) cyc($sformatf("to_hold%0d", i), HOLD);
        cyc("halt", HLT);
        MEM_Ready = 1; EX_BranchTaken = 1; MEM_RegWrite = 1; MEM_WriteReg = 5'd7; EX_Rs = 5'd7;
        for (int i = 0; i < 8; i++) cyc($sformatf("halt_sticky%0d", i), V(1,1,1,0,0,2'b10,2'b00,1));

        // reset while halted with hazards and forwarding present
        RESET = 1;
        cyc("reset_halt", IDLE);
        RESET = 0; MEM_Req = 0; MEM_Ready = 0; EX_BranchTaken = 0; MEM_RegWrite = 0;
        MEM_WriteReg = 5'd0; EX_Rs = 5'd0;
        cyc("post_reset", IDLE);
        MEM_Req = 1;
        cyc("post_reset_hold", HOLD);
        MEM_Req = 0;
        cyc("post_reset_run", IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
